// File: rtl/spi_xfer_ctrl_if.sv
// Bundle of every non-clock, non-reset signal of spi_xfer_ctrl.
// The slave modport is the controller's view. The master modport is the
// view of whatever drives it: the register file on the FIFO side and the
// SPI master on the clock/start side.
interface spi_xfer_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 8
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    // register-file side
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DIV_WIDTH-1:0]  clk_div;
    logic                  cpol;
    logic                  cpha;
    logic                  tx_full;
    logic                  rx_empty;
    logic [LW-1:0]         tx_level;
    logic [LW-1:0]         rx_level;
    logic                  tx_ovf;
    logic                  rx_unf;
    logic                  busy;

    // SPI master side
    logic                  spi_start;
    logic [DATA_WIDTH-1:0] spi_tx_data;
    logic                  spi_cpol;
    logic                  spi_cpha;
    logic                  spi_sclk;
    logic                  spi_sclk_enable;
    logic                  spi_done;
    logic [DATA_WIDTH-1:0] spi_rx_data;

    modport slave (
        input  wr_en, wr_data, rd_en, clk_div, cpol, cpha,
               spi_sclk_enable, spi_done, spi_rx_data,
        output rd_data, tx_full, rx_empty, tx_level, rx_level,
               tx_ovf, rx_unf, busy,
               spi_start, spi_tx_data, spi_cpol, spi_cpha, spi_sclk
    );

    modport master (
        output wr_en, wr_data, rd_en, clk_div, cpol, cpha,
               spi_sclk_enable, spi_done, spi_rx_data,
        input  rd_data, tx_full, rx_empty, tx_level, rx_level,
               tx_ovf, rx_unf, busy,
               spi_start, spi_tx_data, spi_cpol, spi_cpha, spi_sclk
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer controller.
// The TX FIFO feeds one master transfer per word. The RX FIFO
// (first-word-fall-through) collects the received words. SCLK is
// generated from clk using a programmable half-period divider.
// A new transfer is launched only while the RX FIFO has a free slot. A
// transfer that is already running therefore never loses its result.
module spi_xfer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 8
) (
    input  logic             clk,
    input  logic             resetn,
    spi_xfer_ctrl_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = DIV_WIDTH + 1;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [LW-1:0] LVL_MAX = LW'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_ONE = GW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    state_t                 state_reg;
    logic                   spi_start_reg;
    logic [DATA_WIDTH-1:0]  spi_tx_data_reg;
    logic                   cpol_l_reg;
    logic                   cpha_l_reg;
    logic [DIV_WIDTH-1:0]   div_l_reg;
    logic [GW-1:0]          gap_cnt_reg;

    logic [DATA_WIDTH-1:0]  tx_mem [FIFO_DEPTH];
    logic [AW-1:0]          tx_wr_ptr_reg;
    logic [AW-1:0]          tx_rd_ptr_reg;
    logic [LW-1:0]          tx_cnt_reg;

    logic [DATA_WIDTH-1:0]  rx_mem [FIFO_DEPTH];
    logic [AW-1:0]          rx_wr_ptr_reg;
    logic [AW-1:0]          rx_rd_ptr_reg;
    logic [LW-1:0]          rx_cnt_reg;

    logic                   tx_ovf_reg;
    logic                   rx_unf_reg;

    logic                   sclk_reg;
    logic [DIV_WIDTH-1:0]   sclk_cnt_reg;

    logic                   tx_full;
    logic                   tx_empty;
    logic                   rx_full;
    logic                   rx_empty;
    logic                   tx_push;
    logic                   rx_push;
    logic                   rx_pop;
    logic                   launch;
    logic [GW-1:0]          gap_last;

    // FIFO status and the per-cycle push/pop/launch decisions
    always_comb begin
        tx_full  = (tx_cnt_reg == LVL_MAX);
        tx_empty = (tx_cnt_reg == '0);
        rx_full  = (rx_cnt_reg == LVL_MAX);
        rx_empty = (rx_cnt_reg == '0);
        tx_push  = bus.wr_en && !tx_full;
        rx_pop   = bus.rd_en && !rx_empty;
        launch   = (state_reg == S_IDLE) && !tx_empty && !rx_full;
        rx_push  = (state_reg == S_WAIT) && bus.spi_done;
        // GAP holds for div_l+1 cycles after its entry cycle. This keeps
        // the next start at least div_l+5 cycles after spi_done.
        gap_last = {1'b0, div_l_reg} + GAP_ONE;
    end

    // TX storage: written on accepted pushes, read out only at launch
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_reg] <= bus.wr_data;
        end
    end

    // TX pointers and occupancy; a push and a launch pop can coincide
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_cnt_reg    <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_ONE;
            end
            if (launch) begin
                tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_ONE;
            end
            case ({tx_push, launch})
                2'b10:   tx_cnt_reg <= tx_cnt_reg + LVL_ONE;
                2'b01:   tx_cnt_reg <= tx_cnt_reg - LVL_ONE;
                default: tx_cnt_reg <= tx_cnt_reg;
            endcase
        end
    end

    // RX storage: written when the master reports completion
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr_reg] <= bus.spi_rx_data;
        end
    end

    // RX pointers and occupancy; an external pop and a push can coincide
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_cnt_reg    <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_ONE;
            end
            if (rx_pop) begin
                rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_ONE;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt_reg <= rx_cnt_reg + LVL_ONE;
                2'b01:   rx_cnt_reg <= rx_cnt_reg - LVL_ONE;
                default: rx_cnt_reg <= rx_cnt_reg;
            endcase
        end
    end

    // Sticky error flags; only reset clears them
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_ovf_reg <= 1'b0;
            rx_unf_reg <= 1'b0;
        end else begin
            if (bus.wr_en && tx_full) begin
                tx_ovf_reg <= 1'b1;
            end
            if (bus.rd_en && rx_empty) begin
                rx_unf_reg <= 1'b1;
            end
        end
    end

    // Transfer sequencer: launch, start pulse, wait for done, deselect gap
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg       <= S_IDLE;
            spi_start_reg   <= 1'b0;
            spi_tx_data_reg <= '0;
            cpol_l_reg      <= 1'b0;
            cpha_l_reg      <= 1'b0;
            div_l_reg       <= '0;
            gap_cnt_reg     <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    spi_start_reg <= 1'b0;
                    if (launch) begin
                        spi_tx_data_reg <= tx_mem[tx_rd_ptr_reg];
                        cpol_l_reg      <= bus.cpol;
                        cpha_l_reg      <= bus.cpha;
                        div_l_reg       <= bus.clk_div;
                        state_reg       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    spi_start_reg <= 1'b1;
                    state_reg     <= S_START;
                end
                S_START: begin
                    spi_start_reg <= 1'b0;
                    state_reg     <= S_WAIT;
                end
                S_WAIT: begin
                    spi_start_reg <= 1'b0;
                    if (bus.spi_done) begin
                        gap_cnt_reg <= '0;
                        state_reg   <= S_GAP;
                    end
                end
                S_GAP: begin
                    spi_start_reg <= 1'b0;
                    if (gap_cnt_reg == gap_last) begin
                        state_reg <= S_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_ONE;
                    end
                end
                default: begin
                    spi_start_reg <= 1'b0;
                    state_reg     <= S_IDLE;
                end
            endcase
        end
    end

    // SCLK divider. At launch the idle level jumps straight to the new
    // cpol, so SCLK has already settled in SETUP. While the master is not
    // running it, SCLK holds the latched idle level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sclk_reg     <= 1'b0;
            sclk_cnt_reg <= '0;
        end else if (launch) begin
            sclk_reg     <= bus.cpol;
            sclk_cnt_reg <= '0;
        end else if (!bus.spi_sclk_enable) begin
            sclk_reg     <= cpol_l_reg;
            sclk_cnt_reg <= '0;
        end else if (sclk_cnt_reg == div_l_reg) begin
            sclk_reg     <= ~sclk_reg;
            sclk_cnt_reg <= '0;
        end else begin
            sclk_cnt_reg <= sclk_cnt_reg + 1'b1;
        end
    end

    // Output drive
    always_comb begin
        bus.rd_data     = rx_mem[rx_rd_ptr_reg];
        bus.tx_full     = tx_full;
        bus.rx_empty    = rx_empty;
        bus.tx_level    = tx_cnt_reg;
        bus.rx_level    = rx_cnt_reg;
        bus.tx_ovf      = tx_ovf_reg;
        bus.rx_unf      = rx_unf_reg;
        bus.busy        = (state_reg != S_IDLE);
        bus.spi_start   = spi_start_reg;
        bus.spi_tx_data = spi_tx_data_reg;
        bus.spi_cpol    = cpol_l_reg;
        bus.spi_cpha    = cpha_l_reg;
        bus.spi_sclk    = sclk_reg;
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed testbench for spi_xfer_ctrl.
// A small behavioural SPI master runs SCLK for 16 edges, then reports done
// with the transmitted word looped back. It also measures the SCLK period,
// the start-pulse width and the spacing from done to the next start.
module tb_spi_xfer_ctrl;
    localparam int DW = 8;
    localparam int FD = 4;
    localparam int VW = 8;

    logic clk = 1'b0;
    logic resetn;

    spi_xfer_ctrl_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .DIV_WIDTH(VW)) bus ();

    spi_xfer_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .DIV_WIDTH(VW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // master model state
    int          cyc = 0;
    logic        sclk_prev = 1'b0;
    logic        start_prev = 1'b0;
    logic [DW-1:0] cap = '0;
    int          toggles = 0;
    int          rises = 0;
    int          last_rise_cyc = 0;
    int          rise_gap = 0;
    int          start_cnt = 0;
    logic        start_long = 1'b0;
    logic        have_done = 1'b0;
    int          last_done_cyc = 0;
    int          min_gap = 1000000;

    // Behavioural SPI master with loopback
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        sclk_prev  <= bus.spi_sclk;
        start_prev <= bus.spi_start;
        if (!resetn) begin
            bus.spi_sclk_enable <= 1'b0;
            bus.spi_done        <= 1'b0;
            bus.spi_rx_data     <= '0;
            toggles             <= 0;
            have_done           <= 1'b0;
        end else begin
            bus.spi_done <= 1'b0;
            if (bus.spi_start) begin
                start_cnt <= start_cnt + 1;
                if (start_prev) start_long <= 1'b1;
                if (have_done && (cyc - last_done_cyc) < min_gap)
                    min_gap <= cyc - last_done_cyc;
                cap                 <= bus.spi_tx_data;
                bus.spi_sclk_enable <= 1'b1;
                toggles             <= 0;
                rises               <= 0;
            end else if (bus.spi_sclk_enable && (bus.spi_sclk != sclk_prev)) begin
                toggles <= toggles + 1;
                if (bus.spi_sclk) begin
                    rises <= rises + 1;
                    if (rises > 0) rise_gap <= cyc - last_rise_cyc;
                    last_rise_cyc <= cyc;
                end
                if (toggles == 15) begin
                    bus.spi_sclk_enable <= 1'b0;
                    bus.spi_done        <= 1'b1;
                    bus.spi_rx_data     <= cap;
                    last_done_cyc       <= cyc + 1;
                    have_done           <= 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    int s0;

    initial begin
        resetn       = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.rd_en    = 1'b0;
        bus.clk_div  = 8'd1;
        bus.cpol     = 1'b0;
        bus.cpha     = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_busy", bus.busy, 0);
        chk("rst_rx_empty", bus.rx_empty, 1);
        chk("rst_tx_level", bus.tx_level, 0);
        chk("rst_rx_level", bus.rx_level, 0);
        chk("rst_sclk", bus.spi_sclk, 0);
        chk("rst_start", bus.spi_start, 0);
        chk("rst_tx_full", bus.tx_full, 0);
        chk("rst_flags", {bus.tx_ovf, bus.rx_unf}, 0);
        resetn = 1'b1;
        tick();

        // mode 0 loopback, clk_div=1, with the launch timing
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        tick();
        bus.wr_en = 1'b0;
        chk("t1_level_n1", bus.tx_level, 1);
        chk("t1_busy_n1", bus.busy, 0);
        tick();
        chk("t1_busy_setup", bus.busy, 1);
        chk("t1_txdata_setup", bus.spi_tx_data, 8'hA5);
        chk("t1_start_setup", bus.spi_start, 0);
        chk("t1_level_setup", bus.tx_level, 0);
        tick();
        chk("t1_start_pulse", bus.spi_start, 1);
        tick();
        chk("t1_start_end", bus.spi_start, 0);
        for (int i = 0; i < 500 && bus.rx_empty; i++) tick();
        chk("t1_rx_arrived", bus.rx_empty, 0);
        chk("t1_rd_data", bus.rd_data, 8'hA5);
        chk("t1_rx_level", bus.rx_level, 1);
        chk("t1_rises", rises, 8);
        chk("t1_sclk_period", rise_gap, 4);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("t1_rx_level_pop", bus.rx_level, 0);

        // four back-to-back words
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(i + 1);
            tick();
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 2000 && bus.rx_level != 4; i++) tick();
        chk("t2_rx_level", bus.rx_level, 4);
        for (int i = 0; i < 50 && bus.busy; i++) tick();
        chk("t2_busy_drop", bus.busy, 0);
        chk("t2_starts", start_cnt - s0, 4);
        chk("t2_start_width", start_long, 0);
        chk("t2_min_gap_ok", (min_gap >= 6), 1);
        chk("t2_tx_level", bus.tx_level, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_rd_%0d", i), bus.rd_data, i + 1);
            bus.rd_en = 1'b1;
            tick();
            bus.rd_en = 1'b0;
        end
        chk("t2_rx_empty", bus.rx_empty, 1);

        // read from an empty RX FIFO
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("t5_rx_unf", bus.rx_unf, 1);
        chk("t5_rx_level", bus.rx_level, 0);

        // mode 3, clk_div=3; config changed after launch must not matter
        bus.cpol = 1'b1; bus.cpha = 1'b1; bus.clk_div = 8'd3;
        bus.wr_en = 1'b1; bus.wr_data = 8'h3C;
        tick();
        bus.wr_en = 1'b0;
        tick();
        chk("t4_sclk_setup", bus.spi_sclk, 1);
        chk("t4_start_setup", bus.spi_start, 0);
        chk("t4_mode_setup", {bus.spi_cpol, bus.spi_cpha}, 2'b11);
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.clk_div = 8'd0;
        for (int i = 0; i < 500 && bus.rx_empty; i++) tick();
        chk("t4_rx_arrived", bus.rx_empty, 0);
        chk("t4_rd_data", bus.rd_data, 8'h3C);
        chk("t4_sclk_period", rise_gap, 8);
        chk("t4_mode_stable", {bus.spi_cpol, bus.spi_cpha}, 2'b11);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;

        // RX fills, launches stall, TX fills, overflow; one read frees one launch
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h10 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 2000 && bus.rx_level != 4; i++) tick();
        for (int i = 0; i < 50 && bus.busy; i++) tick();
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h20 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        repeat (5) tick();
        chk("t3_rx_full", bus.rx_level, 4);
        chk("t3_tx_level", bus.tx_level, 4);
        chk("t3_tx_full", bus.tx_full, 1);
        chk("t3_tx_ovf", bus.tx_ovf, 1);
        chk("t3_idle", bus.busy, 0);
        chk("t3_head", bus.rd_data, 8'h10);
        s0 = start_cnt;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        for (int i = 0; i < 500 && bus.rx_level != 4; i++) tick();
        for (int i = 0; i < 50 && bus.busy; i++) tick();
        repeat (10) tick();
        chk("t3_one_launch", start_cnt - s0, 1);
        chk("t3_tx_after", bus.tx_level, 3);
        chk("t3_rx_after", bus.rx_level, 4);
        chk("t3_head_after", bus.rd_data, 8'h11);

        // reset while the master is running
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        for (int i = 0; i < 50 && !bus.spi_sclk_enable; i++) tick();
        chk("t6_in_wait", bus.spi_sclk_enable, 1);
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        chk("t6_busy", bus.busy, 0);
        chk("t6_sclk", bus.spi_sclk, 0);
        chk("t6_levels", {bus.tx_level, bus.rx_level}, 0);
        chk("t6_start", bus.spi_start, 0);
        chk("t6_flags", {bus.tx_ovf, bus.rx_unf}, 0);
        resetn = 1'b1;
        tick();
        bus.wr_en = 1'b1; bus.wr_data = 8'h5A;
        tick();
        bus.wr_en = 1'b0;
        for (int i = 0; i < 500 && bus.rx_empty; i++) tick();
        chk("t6_rx_arrived", bus.rx_empty, 0);
        chk("t6_rd_data", bus.rd_data, 8'h5A);
        chk("t6_rx_level", bus.rx_level, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

Transfer controller that sits directly upstream of the SPI master and drives its whole clock/start side. It buffers bytes written from the AXI-Lite register file in a TX FIFO and launches one master transfer per byte. It generates the master's SCLK from the system clock with a programmable divider, and stores each received word in an RX FIFO for the register file to read back.

## Interface
Parameters:
- DATA_WIDTH, 8, SPI word width; must match the master.
- FIFO_DEPTH, 4, depth of the TX and RX FIFOs; power of 2, ≥2.
- DIV_WIDTH, 8, width of the clock-divider setting.

Ports (LW = $clog2(FIFO_DEPTH)+1):
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- wr_en  in  1  push wr_data into the TX FIFO.
- wr_data  in  DATA_WIDTH  TX word.
- rd_en  in  1  pop the RX FIFO head.
- rd_data  out  DATA_WIDTH  RX FIFO head; valid while rx_empty=0.
- clk_div  in  DIV_WIDTH  SCLK half-period minus 1, in clk cycles.
- cpol, cpha  in  1 each  SPI mode for the next transfer.
- tx_full, rx_empty  out  1 each  FIFO flags.
- tx_level, rx_level  out  LW  FIFO occupancy.
- tx_ovf, rx_unf  out  1 each  sticky error flags; cleared only by reset.
- busy  out  1  high whenever the FSM is not in IDLE.
- spi_start  out  1  one-cycle start pulse to the master.
- spi_tx_data  out  DATA_WIDTH  word for the master.
- spi_cpol, spi_cpha  out  1 each  latched mode bits to the master.
- spi_sclk  out  1  generated SCLK.
- spi_sclk_enable  in  1  the master's SCLK-run request.
- spi_done  in  1  the master's one-cycle completion pulse.
- spi_rx_data  in  DATA_WIDTH  the master's received word.

## Operation
- Reset values: all registered outputs 0, FIFOs empty (rx_empty=1, levels 0), flags 0, FSM in IDLE. Latched cpol/cpha/div reset to 0.
- TX FIFO:
  - wr_en with tx_full=1: the write is dropped and tx_ovf is set.
  - A write and an internal pop in the same cycle are both honoured.
- RX FIFO:
  - rd_data is first-word-fall-through.
  - rd_en with rx_empty=1: ignored, rx_unf is set.
  - An external pop and an internal push in the same cycle are both honoured.
- FSM, states IDLE, SETUP, START, WAIT, GAP:
  - IDLE: if the TX FIFO is non-empty and rx_level < FIFO_DEPTH, pop the TX head into spi_tx_data and latch cpol, cpha, clk_div; go to SETUP. Otherwise stay.
  - SETUP: one cycle so that spi_sclk settles at the new idle level; set spi_start<=1 and go to START.
  - START: spi_start<=0; go to WAIT.
  - WAIT: on spi_done, push spi_rx_data into the RX FIFO; go to GAP.
  - GAP: count div_l+1 cycles (minimum deselect time), then go to IDLE.
- An RX FIFO full condition stalls new launches only. A transfer already in flight always finds a free RX slot, because a launch requires a free slot.
- SCLK generator:
  - When spi_sclk_enable=0: spi_sclk<=cpol_l and the counter is cleared.
  - When spi_sclk_enable=1: the counter increments; when it equals div_l, spi_sclk toggles and the counter clears. Half period = div_l+1 clk cycles.
- Config inputs changed mid-transfer have no effect until the next IDLE launch.
- Reset mid-transfer: state, FIFOs, flags and spi_sclk clear on the next clk edge. spi_start is forced to 0.

## Timing
- Cycle N: wr_en (FIFO was empty). N+1: tx_level=1 and the FSM is in IDLE with the launch condition true. N+2: SETUP, spi_tx_data valid, spi_cpol/spi_cpha valid. N+3: START with spi_start=1 for exactly one cycle.
- spi_tx_data, spi_cpol and spi_cpha are stable from SETUP until the next launch.
- spi_done in cycle M: rx_empty=0 and rd_data valid at M+1.
- Back-to-back transfers: the next spi_start comes no earlier than div_l+5 cycles after spi_done.
- clk_div=0: spi_sclk toggles every enabled cycle, giving a period of 2 clk cycles.

## Test plan
- Mode 0 loopback (master MISO tied to MOSI), clk_div=1, write 0xA5 -> rd_data=0xA5, rx_level=1, SCLK period 4 clk cycles, exactly 8 rising edges.
- Write 0x01,0x02,0x03,0x04 back-to-back -> 4 transfers, each with a single spi_start pulse; RX FIFO reads 0x01..0x04 in order; busy drops after the final GAP.
- With no reads, write 12 words -> RX FIFO fills at 4 and launches stop; TX FIFO fills to 4; 4 further writes are dropped and tx_ovf=1. One rd_en then triggers exactly one new launch.
- cpol=1, cpha=1, clk_div=3 -> spi_sclk already high in SETUP before spi_start; half period 4 cycles; loopback 0x3C returns 0x3C.
- rd_en with rx_empty=1 -> rx_unf=1, rx_level stays 0.
- resetn low during WAIT -> next cycle: busy=0, spi_sclk=0, levels 0, spi_start=0. A subsequent write of 0x5A completes normally.
